// File: rtl/ifetch_buffer_if.sv
// Fetch-stage bundle: PC register link, instruction-memory request/response,
// and the {pc, inst} valid/ready channel toward decode.
interface ifetch_buffer_if;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        flush;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  modport master (
    input  pc, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    output npc, imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst
  );

  modport slave (
    output pc, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    input  npc, imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst
  );
endinterface

// File: rtl/ifetch_buffer.sv
// Fetch issue with credit-limited outstanding requests, in-order response
// tagging, squash accounting on redirect, and a {pc, inst} FIFO to decode.
module ifetch_buffer #(
  parameter int DEPTH = 2
) (
  input logic             clk,
  input logic             rst_n,
  ifetch_buffer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LP_DEPTH = DEPTH[CW:0];

  // state   | meaning
  // ST_BOOT | first cycle after reset; no request, npc steps the reset PC to 0
  // ST_RUN  | normal fetch issue, response buffering and flush handling
  typedef enum logic {ST_BOOT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        r_state;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_tag_wr_ptr;
  logic [AW-1:0] r_tag_rd_ptr;
  logic [31:0]   r_tag       [DEPTH];
  logic [31:0]   r_fifo_pc   [DEPTH];
  logic [31:0]   r_fifo_inst [DEPTH];

  logic          w_run;
  logic [CW:0]   w_used;
  logic          w_req_valid;
  logic          w_fire;
  logic          w_rsp;
  logic          w_rsp_drop;
  logic          w_rsp_push;
  logic          w_pop;
  logic [CW-1:0] w_rsp_dec;

  assign w_run       = (r_state == ST_RUN);
  assign w_used      = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_req_valid = w_run && !bus.flush && (w_used < LP_DEPTH);
  assign w_fire      = w_req_valid && bus.imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp       = bus.imem_rsp_valid && (r_outstanding != '0);
  assign w_rsp_drop  = w_rsp && (r_drop_cnt != '0);
  assign w_rsp_push  = w_rsp && (r_drop_cnt == '0);
  assign w_pop       = (r_count != '0) && bus.id_ready;
  assign w_rsp_dec   = CW'(w_rsp);

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = bus.pc;
  assign bus.npc            = (!w_run || w_fire) ? bus.pc + 32'd4 : bus.pc;
  assign bus.id_valid       = (r_count != '0);
  assign bus.id_pc          = r_fifo_pc[r_rd_ptr];
  assign bus.id_inst        = r_fifo_inst[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_tag_wr_ptr  <= '0;
      r_tag_rd_ptr  <= '0;
    end else if (r_state == ST_BOOT) begin
      r_state <= ST_RUN;
    end else if (bus.flush) begin
      // Everything still owed by memory becomes a squashed response.
      r_drop_cnt    <= r_outstanding - w_rsp_dec;
      r_outstanding <= r_outstanding - w_rsp_dec;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_tag_wr_ptr  <= '0;
      r_tag_rd_ptr  <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_fire) - w_rsp_dec;
      r_count       <= r_count + CW'(w_rsp_push) - CW'(w_pop);
      if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
      if (w_fire) r_tag_wr_ptr <= r_tag_wr_ptr + AW'(1);
      if (w_rsp_push) begin
        r_tag_rd_ptr <= r_tag_rd_ptr + AW'(1);
        r_wr_ptr     <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_run && !bus.flush) begin
      if (w_fire) r_tag[r_tag_wr_ptr] <= bus.pc;
      if (w_rsp_push) begin
        r_fifo_pc[r_wr_ptr]   <= r_tag[r_tag_rd_ptr];
        r_fifo_inst[r_wr_ptr] <= bus.imem_rsp_data;
      end
    end
  end
endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed and randomized checks of ifetch_buffer against a queue-based model
// of the fetch stage, with the PC register and memory modelled in the bench.
module tb_ifetch_buffer;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] XK     = 32'hA5A5_0000;
  localparam logic [31:0] PC_RST = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic rst_n;

  ifetch_buffer_if bus();
  ifetch_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; int due;} mreq_t;
  typedef struct {logic [31:0] addr; bit live;} infl_t;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;

  mreq_t mem_q[$];
  infl_t m_infl[$];
  ent_t  m_buf[$];
  bit    m_boot;
  int    lat;
  int    cyc;
  int    n_cmp;
  int    n_err;
  int    obs_fires;
  bit    first_seen;
  logic [31:0] first_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit fl, input bit rdy, input bit idr, input logic [31:0] tgt);
    logic        rv;
    logic [31:0] rd;
    logic        exp_req;
    logic        exp_fire;
    logic [31:0] exp_npc;
    bus.flush          = fl;
    bus.imem_req_ready = rdy;
    bus.id_ready       = idr;
    rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rd = rv ? (mem_q[0].addr ^ XK) : $urandom;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rd;
    exp_req  = !m_boot && !fl && ((m_infl.size() + m_buf.size()) < DEPTH);
    exp_fire = exp_req && rdy;
    exp_npc  = (m_boot || exp_fire) ? bus.pc + 32'd4 : bus.pc;
    @(negedge clk);
    chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
    chk("npc", bus.npc, exp_npc);
    if (exp_req) chk("req_addr", bus.imem_req_addr, bus.pc);
    chk("id_valid", 32'(bus.id_valid), 32'(m_buf.size() != 0));
    if (m_buf.size() != 0) begin
      chk("id_pc", bus.id_pc, m_buf[0].pc);
      chk("id_inst", bus.id_inst, m_buf[0].inst);
    end
    if (bus.id_valid && !first_seen) begin
      first_seen = 1'b1;
      first_pc   = bus.id_pc;
    end
    if (bus.imem_req_valid && rdy) obs_fires++;
    @(posedge clk);
    #1;
    if (rv) mem_q.delete(0);
    if (m_boot) begin
      m_boot = 1'b0;
    end else begin
      if (!fl && idr && m_buf.size() != 0) m_buf.delete(0);
      if (rv && m_infl.size() != 0) begin
        if (m_infl[0].live && !fl) m_buf.push_back('{m_infl[0].addr, rd});
        m_infl.delete(0);
      end
      if (fl) begin
        m_buf.delete();
        foreach (m_infl[i]) m_infl[i].live = 1'b0;
      end
      if (exp_fire) begin
        m_infl.push_back('{bus.pc, 1'b1});
        mem_q.push_back('{bus.pc, cyc + lat});
      end
    end
    bus.pc = fl ? tgt : exp_npc;
    cyc++;
  endtask

  task automatic do_reset();
    bus.flush          = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.id_ready       = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    bus.pc = PC_RST;
    mem_q.delete();
    m_infl.delete();
    m_buf.delete();
    m_boot = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && (m_infl.size() + m_buf.size() != 0); k++) tick(1'b0, 1'b0, 1'b1, '0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    lat   = 1;
    first_seen = 1'b0;
    first_pc   = 32'hDEAD_BEEF;
    bus.pc = PC_RST;
    rst_n  = 1'b1;
    #2;
    do_reset();

    // boot then 1-cycle streaming
    for (int k = 0; k < 20; k++) tick(1'b0, 1'b1, 1'b1, '0);
    chk("stream_first_pc", first_pc, 32'h0);

    // backpressure: only DEPTH fetches may issue
    drain();
    obs_fires = 0;
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b1, 1'b0, '0);
    chk("bp_fires", 32'(obs_fires), 32'd2);
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b1, 1'b1, '0);

    // flush with two in flight on a 3-cycle memory
    drain();
    lat = 3;
    tick(1'b0, 1'b1, 1'b1, '0);
    tick(1'b0, 1'b1, 1'b1, '0);
    tick(1'b1, 1'b1, 1'b1, 32'h100);
    first_seen = 1'b0;
    first_pc   = 32'hDEAD_BEEF;
    for (int k = 0; k < 12; k++) tick(1'b0, 1'b1, 1'b1, '0);
    chk("flush_first_pc", first_pc, 32'h100);

    // flush coinciding with a response on a 2-cycle memory
    drain();
    lat = 2;
    tick(1'b0, 1'b1, 1'b1, '0);
    tick(1'b0, 1'b1, 1'b1, '0);
    tick(1'b1, 1'b1, 1'b1, 32'h200);
    tick(1'b0, 1'b0, 1'b1, '0);
    chk("drop_cnt_zero", 32'(dut.r_drop_cnt), 32'd0);
    first_seen = 1'b0;
    first_pc   = 32'hDEAD_BEEF;
    for (int k = 0; k < 8; k++) tick(1'b0, 1'b1, 1'b1, '0);
    chk("flush_rsp_first_pc", first_pc, 32'h200);

    // reset while two entries are buffered
    drain();
    lat = 1;
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 1'b0, '0);
    chk("pre_reset_id_valid", 32'(bus.id_valid), 32'd1);
    do_reset();
    first_seen = 1'b0;
    first_pc   = 32'hDEAD_BEEF;
    for (int k = 0; k < 8; k++) tick(1'b0, 1'b1, 1'b1, '0);
    chk("restart_first_pc", first_pc, 32'h0);

    // randomized traffic, flushes and backpressure
    for (int ph = 0; ph < 6; ph++) begin
      drain();
      lat = $urandom_range(1, 3);
      for (int k = 0; k < 80; k++) begin
        tick(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) != 0), $urandom & 32'hFFFF_FFFC);
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
